// File: rtl/fog_dac_pkg.sv
// fog_dac_pkg: shared state encoding, default DAC command and frame sizing for the FOG DAC path
package fog_dac_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    localparam logic [7:0] DEFAULT_CMD = 8'h30;
    function automatic int frame_w(input int cmd_w, input int data_w);
        return cmd_w + data_w;
    endfunction
endpackage

// File: rtl/fog_sat_shift.sv
// fog_sat_shift: arithmetic shift, signed saturation and optional offset-binary coding of a drive word
module fog_sat_shift #(
    parameter int IN_W = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 12,
    parameter bit OFFSET_BIN = 1'b1
)(
    input  logic signed [IN_W-1:0] data,
    output logic        [OUT_W-1:0] code
);
    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;
    logic signed [IN_W-1:0] s;
    logic [OUT_W-1:0] sat;
    // scale down, clamp into the signed DAC range, then flip the sign bit for offset binary
    always_comb begin
        s = data >>> SHIFT;
        sat = (s > MAX_V) ? MAX_V[OUT_W-1:0] : (s < MIN_V) ? MIN_V[OUT_W-1:0] : s[OUT_W-1:0];
        code = {sat[OUT_W-1] ^ OFFSET_BIN, sat[OUT_W-2:0]};
    end
endmodule

// File: rtl/fog_dac_spi_tx.sv
// fog_dac_spi_tx: codes the FOG phase word and sends it to an SPI DAC as a command+data frame
module fog_dac_spi_tx
    import fog_dac_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IN_SHIFT = 12,
    parameter int CMD_W = 8,
    parameter logic [CMD_W-1:0] CMD_WORD = CMD_W'(DEFAULT_CMD),
    parameter int CLK_DIV = 2,
    parameter int CS_GAP = 2,
    parameter bit OFFSET_BIN = 1'b1
)(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic signed [31:0] i_data,
    input  logic               i_valid,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_drop,
    output logic               o_sclk,
    output logic               o_cs_n,
    output logic               o_sdi
);
    localparam int FRAME_W = frame_w(CMD_W, DATA_W);
    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam int BW = $clog2(FRAME_W);
    localparam int GW = $clog2(CS_GAP) + 1;
    state_t state;
    logic [DATA_W-1:0] code;
    logic [FRAME_W-1:0] frame_in, pend, shreg, load_word;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bitc;
    logic [GW-1:0] gcnt;
    logic pend_v, ph, load, gap_last;

    fog_sat_shift #(.IN_W(32), .OUT_W(DATA_W), .SHIFT(IN_SHIFT), .OFFSET_BIN(OFFSET_BIN)) u_sat (
        .data(i_data),
        .code(code)
    );

    assign frame_in = {CMD_WORD, code};
    assign o_sdi = shreg[FRAME_W-1];

    // start a frame from idle, or straight out of the last gap cycle when a word is waiting
    always_comb begin
        gap_last = gcnt == GW'(CS_GAP - 1);
        load = (state == IDLE && i_valid) || (state == GAP && gap_last && (i_valid || pend_v));
        load_word = i_valid ? frame_in : pend;
    end

    // frame sequencer with one-deep newest-wins pending buffer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            o_drop <= 1'b0;
            o_sclk <= 1'b0;
            o_cs_n <= 1'b1;
            shreg <= '0;
            pend <= '0;
            pend_v <= 1'b0;
            ph <= 1'b0;
            cnt <= '0;
            bitc <= '0;
            gcnt <= '0;
        end else begin
            o_done <= 1'b0;
            o_drop <= i_valid && state != IDLE && pend_v;
            if (i_valid && state != IDLE) begin
                pend <= frame_in;
                pend_v <= 1'b1;
            end
            if (load) begin
                state <= SHIFT;
                shreg <= load_word;
                pend_v <= 1'b0;
                o_cs_n <= 1'b0;
                o_sclk <= 1'b0;
                o_busy <= 1'b1;
                ph <= 1'b0;
                cnt <= '0;
                bitc <= '0;
            end else if (state == SHIFT) begin
                if (cnt != CW'(CLK_DIV - 1)) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    cnt <= '0;
                    if (!ph) begin
                        ph <= 1'b1;
                        o_sclk <= 1'b1;
                    end else if (bitc == BW'(FRAME_W - 1)) begin
                        state <= GAP;
                        gcnt <= '0;
                        shreg <= '0;
                        o_cs_n <= 1'b1;
                        o_sclk <= 1'b0;
                        o_done <= 1'b1;
                    end else begin
                        ph <= 1'b0;
                        o_sclk <= 1'b0;
                        bitc <= bitc + 1'b1;
                        shreg <= {shreg[FRAME_W-2:0], 1'b0};
                    end
                end
            end else if (state == GAP) begin
                if (gap_last) begin
                    state <= IDLE;
                    o_busy <= 1'b0;
                end else begin
                    gcnt <= gcnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fog_dac_spi_tx.sv
// tb_fog_dac_spi_tx: directed checks of framing, coding, pending buffer, reset abort and fast SCLK
module tb_fog_dac_spi_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [31:0] data0 = '0, data1 = '0;
    logic valid0 = 1'b0, valid1 = 1'b0;
    logic busy0, done0, drop0, sclk0, cs0, sdi0;
    logic busy1, done1, drop1, sclk1, cs1, sdi1;
    int checks = 0, errors = 0;
    int done_cnt0 = 0, drop_cnt0 = 0, done_cnt1 = 0, drop_cnt1 = 0;

    always #5 clk = ~clk;

    fog_dac_spi_tx #(.CLK_DIV(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(data0), .i_valid(valid0),
        .o_busy(busy0), .o_done(done0), .o_drop(drop0), .o_sclk(sclk0), .o_cs_n(cs0), .o_sdi(sdi0)
    );

    fog_dac_spi_tx #(.CLK_DIV(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_data(data1), .i_valid(valid1),
        .o_busy(busy1), .o_done(done1), .o_drop(drop1), .o_sclk(sclk1), .o_cs_n(cs1), .o_sdi(sdi1)
    );

    always @(negedge clk) begin
        if (done0) done_cnt0++;
        if (drop0) drop_cnt0++;
        if (done1) done_cnt1++;
        if (drop1) drop_cnt1++;
    end

    function automatic logic [23:0] exp_frame(input logic signed [31:0] d);
        logic signed [31:0] s, c;
        s = d >>> 12;
        c = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
        return {8'h30, c[15:0] ^ 16'h8000};
    endfunction

    task automatic strobe(input bit sel, input logic signed [31:0] d);
        @(negedge clk);
        if (sel) begin data1 = d; valid1 = 1'b1; end
        else begin data0 = d; valid0 = 1'b1; end
        @(negedge clk);
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    task automatic capture(input bit sel, output logic [23:0] f, output int waited, output int low,
                           output int perr, output logic done_end, output logic sclk_end);
        int dv;
        logic prev;
        dv = sel ? 1 : 2;
        f = '0; waited = 0; low = 0; perr = 0; prev = 1'b0;
        while ((sel ? cs1 : cs0) && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        while (!(sel ? cs1 : cs0) && low < 400) begin
            if ((sel ? sclk1 : sclk0) !== 1'((low / dv) % 2)) perr++;
            if ((sel ? sclk1 : sclk0) && !prev) f = {f[22:0], sel ? sdi1 : sdi0};
            prev = sel ? sclk1 : sclk0;
            @(negedge clk);
            low++;
        end
        done_end = sel ? done1 : done0;
        sclk_end = sel ? sclk1 : sclk0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({cs0, sclk0, sdi0, busy0, done0, drop0} !== 6'b100000) begin
            errors++;
            $display("FAIL reset0 got %b exp 100000", {cs0, sclk0, sdi0, busy0, done0, drop0});
        end
        checks++;
        if ({cs1, sclk1, sdi1, busy1, done1, drop1} !== 6'b100000) begin
            errors++;
            $display("FAIL reset1 got %b exp 100000", {cs1, sclk1, sdi1, busy1, done1, drop1});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        logic [23:0] f;
        int w, low, perr, d0;
        logic de, se;
        d0 = done_cnt0;
        strobe(0, 32'h0123_4000);
        capture(0, f, w, low, perr, de, se);
        checks++;
        if (f !== 24'h30_9234) begin errors++; $display("FAIL single_frame got %h exp 309234", f); end
        checks++;
        if (w !== 0 || low !== 96) begin errors++; $display("FAIL single_timing wait %0d low %0d exp 0 96", w, low); end
        checks++;
        if (perr !== 0 || de !== 1'b1 || se !== 1'b0) begin
            errors++; $display("FAIL single_end perr %0d done %b sclk %b exp 0 1 0", perr, de, se);
        end
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b1 || sdi0 !== 1'b0) begin errors++; $display("FAIL single_gap busy %b sdi %b exp 1 0", busy0, sdi0); end
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL single_idle busy %b exp 0", busy0); end
        checks++;
        if (done_cnt0 - d0 !== 1) begin errors++; $display("FAIL single_done_count got %0d exp 1", done_cnt0 - d0); end
    endtask

    task automatic test_saturation();
        logic [31:0] vals [3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000};
        logic [15:0] codes [3] = '{16'hFFFF, 16'h0000, 16'h8000};
        logic [23:0] f;
        int w, low, perr;
        logic de, se;
        for (int i = 0; i < 3; i++) begin
            strobe(0, vals[i]);
            capture(0, f, w, low, perr, de, se);
            checks++;
            if (f !== {8'h30, codes[i]}) begin errors++; $display("FAIL sat_%0d got %h exp %h", i, f, {8'h30, codes[i]}); end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] fa, fb;
        int w, low, perr, dr;
        logic de, se;
        dr = drop_cnt0;
        strobe(0, 32'h0001_0000);
        fork
            capture(0, fa, w, low, perr, de, se);
            begin
                repeat (9) @(negedge clk);
                strobe(0, 32'hFFFF_0000);
            end
        join
        capture(0, fb, w, low, perr, de, se);
        checks++;
        if (fa !== exp_frame(32'h0001_0000)) begin errors++; $display("FAIL b2b_a got %h exp %h", fa, exp_frame(32'h0001_0000)); end
        checks++;
        if (fb !== exp_frame(32'hFFFF_0000)) begin errors++; $display("FAIL b2b_b got %h exp %h", fb, exp_frame(32'hFFFF_0000)); end
        checks++;
        if (w !== 2 || low !== 96) begin errors++; $display("FAIL b2b_gap gap %0d low %0d exp 2 96", w, low); end
        checks++;
        if (drop_cnt0 - dr !== 0) begin errors++; $display("FAIL b2b_drop got %0d exp 0", drop_cnt0 - dr); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_overwrite();
        logic [23:0] fa, fc;
        int w, low, perr, dr;
        logic de, se;
        dr = drop_cnt0;
        strobe(0, 32'h0002_0000);
        fork
            capture(0, fa, w, low, perr, de, se);
            begin
                repeat (9) @(negedge clk);
                strobe(0, 32'h0003_0000);
                repeat (9) @(negedge clk);
                strobe(0, 32'h0004_0000);
            end
        join
        capture(0, fc, w, low, perr, de, se);
        checks++;
        if (fa !== exp_frame(32'h0002_0000)) begin errors++; $display("FAIL ovw_a got %h exp %h", fa, exp_frame(32'h0002_0000)); end
        checks++;
        if (fc !== exp_frame(32'h0004_0000)) begin errors++; $display("FAIL ovw_c got %h exp %h", fc, exp_frame(32'h0004_0000)); end
        checks++;
        if (drop_cnt0 - dr !== 1) begin errors++; $display("FAIL ovw_drop got %0d exp 1", drop_cnt0 - dr); end
        repeat (8) @(negedge clk);
        checks++;
        if (cs0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL ovw_no_b cs %b busy %b exp 1 0", cs0, busy0); end
    endtask

    task automatic test_reset_abort();
        logic [23:0] f;
        int w, low, perr, d0;
        logic de, se;
        d0 = done_cnt0;
        strobe(0, 32'h0005_0000);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cs0, sclk0, busy0} !== 3'b100) begin errors++; $display("FAIL abort_lines got %b exp 100", {cs0, sclk0, busy0}); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt0 - d0 !== 0) begin errors++; $display("FAIL abort_done got %0d exp 0", done_cnt0 - d0); end
        strobe(0, 32'hF123_4567);
        capture(0, f, w, low, perr, de, se);
        checks++;
        if (f !== exp_frame(32'hF123_4567) || low !== 96 || de !== 1'b1) begin
            errors++; $display("FAIL abort_recover got %h low %0d done %b exp %h 96 1", f, low, de, exp_frame(32'hF123_4567));
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_fast_sclk();
        logic [23:0] f;
        logic signed [31:0] d;
        int w, low, perr, dr, bad;
        logic de, se;
        dr = drop_cnt1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            d = i * 32'sh0213_7000 - 32'sh6000_0000;
            strobe(1, d);
            capture(1, f, w, low, perr, de, se);
            checks++;
            if (f !== exp_frame(d) || low !== 48 || perr !== 0 || w !== 0 || de !== 1'b1) begin
                errors++; bad++;
                if (bad < 5) $display("FAIL fast_%0d got %h low %0d perr %0d wait %0d done %b exp %h 48 0 0 1",
                                      i, f, low, perr, w, de, exp_frame(d));
            end
        end
        checks++;
        if (drop_cnt1 - dr !== 0) begin errors++; $display("FAIL fast_drop got %0d exp 0", drop_cnt1 - dr); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturation();
        test_back_to_back();
        test_overwrite();
        test_reset_abort();
        test_fast_sclk();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
